// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack fetch from instruction memory and
// valid/ready hand-off to the decoder. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic [1:0]  branch,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] signimm,
  output logic [31:0] retired_cnt,
  output logic [31:0] redirect_cnt
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4;
  logic [31:0] pcbranch;
  logic [31:0] pc_next;
  logic        retire;

  // The branch offset is a word offset; its top two bits fall off the shift.
  logic unused_signimm;
  assign unused_signimm = ^signimm[31:30];

  assign pcplus4  = pc_q + 32'd4;
  assign pcbranch = pcplus4 + {signimm[29:0], 2'b00};

  // Jump outranks any branch the decoder might also assert; branch=01 is never taken.
  always_comb begin
    pc_next = pcplus4;
    if (jump) begin
      pc_next = {pcplus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch == 2'b10 && zero) begin
      pc_next = pcbranch;
    end else if (branch == 2'b11 && !zero) begin
      pc_next = pcbranch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          retire  = 1'b1;
          pc_d    = pc_next;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] redirect_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q  <= '0;
      redirect_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
      if (pc_next != pcplus4) begin
        redirect_q <= redirect_q + 32'd1;
      end
    end
  end

  assign retired_cnt  = retired_q;
  assign redirect_cnt = redirect_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired_cnt   = '0;
  assign redirect_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (RESET_PC = 0).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [1:0]  branch = 2'b00;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] signimm = '0;
  logic [31:0] retired_cnt;
  logic [31:0] redirect_cnt;

  logic        auto_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_word = '0;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] J10  = {6'h02, 26'h000_0010};
  localparam logic [31:0] J00  = {6'h02, 26'h000_0000};
  localparam logic [31:0] BEQW = 32'h1000_1234;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .branch(branch), .jump(jump), .zero(zero), .signimm(signimm),
    .retired_cnt(retired_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  // Zero-wait-state memory model: word content derived from its address.
  assign imem_ack   = (auto_ack & imem_req) | force_ack;
  assign imem_rdata = ovr_en ? ovr_word : (imem_addr ^ 32'h8C00_0000);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_ready = 1'b0; auto_ack = 1'b0; force_ack = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic fetch_with(input logic [31:0] w);
    ovr_word = w; ovr_en = 1'b1; auto_ack = 1'b1;
    for (int i = 0; i < 8 && !instr_valid; i++) step();
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: instr_valid=%b required 1", instr_valid);
    end
    ovr_en = 1'b0; auto_ack = 1'b0;
  endtask

  task automatic retire(input logic j, input logic [1:0] b, input logic z, input logic [31:0] imm);
    jump = j; branch = b; zero = z; signimm = imm; instr_ready = 1'b1;
    step();
    jump = 1'b0; branch = 2'b00; zero = 1'b0; signimm = '0; instr_ready = 1'b0;
  endtask

  task automatic chk_addr(input string name, input logic [31:0] exp);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp) begin
      errors++;
      $display("FAIL %s: req=%b addr=%h required req=1 addr=%h", name, imem_req, imem_addr, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b required 1", imem_req); end
    checks++;
    if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", instr_valid); end
    checks++;
    if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h required 0", instr); end
    checks++;
    if (retired_cnt !== 32'h0 || redirect_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: got %h/%h required 0/0", retired_cnt, redirect_cnt);
    end
  endtask

  task automatic test_sequential();
    auto_ack = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL seq_fetch%0d: req=%b addr=%h valid=%b required 1/%h/0",
                 k, imem_req, imem_addr, instr_valid, 32'(4 * k));
      end
      step();
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== (32'(4 * k) ^ 32'h8C00_0000)) begin
        errors++;
        $display("FAIL seq_hold%0d: valid=%b req=%b instr=%h required 1/0/%h",
                 k, instr_valid, imem_req, instr, 32'(4 * k) ^ 32'h8C00_0000);
      end
      step();
    end
    auto_ack = 1'b0; instr_ready = 1'b0;
    chk_addr("seq_end", 32'h10);
  endtask

  task automatic test_beq();
    fetch_with(J10);  retire(1'b1, 2'b00, 1'b0, 32'h0);
    chk_addr("to_40", 32'h40);
    fetch_with(BEQW); retire(1'b0, 2'b10, 1'b1, 32'hFFFF_FFFE);
    chk_addr("beq_taken", 32'h3C);
    fetch_with(J10);  retire(1'b1, 2'b00, 1'b0, 32'h0);
    fetch_with(BEQW); retire(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE);
    chk_addr("beq_not_taken", 32'h44);
  endtask

  task automatic test_bne();
    fetch_with(J10);  retire(1'b1, 2'b00, 1'b0, 32'h0);
    fetch_with(BEQW); retire(1'b0, 2'b11, 1'b0, 32'h3);
    chk_addr("bne_taken", 32'h50);
    fetch_with(J10);  retire(1'b1, 2'b00, 1'b0, 32'h0);
    fetch_with(BEQW); retire(1'b0, 2'b11, 1'b1, 32'h3);
    chk_addr("bne_not_taken", 32'h44);
    fetch_with(BEQW); retire(1'b0, 2'b01, 1'b1, 32'h3);
    chk_addr("branch01_ignored", 32'h48);
  endtask

  task automatic test_jump();
    fetch_with(J10);  retire(1'b1, 2'b00, 1'b0, 32'h0);
    fetch_with(BEQW); retire(1'b0, 2'b10, 1'b1, 32'h03FF_FFEF);
    chk_addr("far_branch", 32'h1000_0000);
    fetch_with(J10);  retire(1'b1, 2'b00, 1'b0, 32'h0);
    chk_addr("jump_region", 32'h1000_0040);
    fetch_with(J00);  retire(1'b1, 2'b00, 1'b0, 32'h0);
    chk_addr("jump_back", 32'h1000_0000);
    fetch_with(J10);  retire(1'b1, 2'b10, 1'b1, 32'h5);
    chk_addr("jump_wins", 32'h1000_0040);
  endtask

  task automatic test_hold_stall();
    logic [31:0] p;
    fetch_with(32'hDEAD_BEEF);
    p = pc;
    ovr_en = 1'b1; ovr_word = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      force_ack = i[0];
      step();
      checks++;
      if (instr !== 32'hDEAD_BEEF || pc !== p || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d: instr=%h pc=%h req=%b valid=%b required DEADBEEF/%h/0/1",
                 i, instr, pc, imem_req, instr_valid, p);
      end
    end
    force_ack = 1'b0; ovr_en = 1'b0;
    retire(1'b0, 2'b00, 1'b0, 32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== p + 32'd4 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL ready_in_fetch%0d: pc=%h valid=%b req=%b required %h/0/1",
                 i, pc, instr_valid, imem_req, p + 32'd4);
      end
    end
    instr_ready = 1'b0;
    auto_ack = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; auto_ack = 1'b0;
    checks++;
    if (imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_with_ack: addr=%h valid=%b instr=%h req=%b required 0/0/0/1",
               imem_addr, instr_valid, instr, imem_req);
    end
    fetch_with(J10); retire(1'b1, 2'b00, 1'b0, 32'h0);
    fetch_with(BEQW);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (imem_addr !== 32'h0 || instr_valid !== 1'b0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_hold: addr=%h valid=%b pc=%h required 0/0/0", imem_addr, instr_valid, pc);
    end
  endtask

  task automatic test_counters();
    logic [31:0] exp_ret, exp_red;
`ifdef FETCH_PERF_CNT_EN
    exp_ret = 32'd10; exp_red = 32'd4;
`else
    exp_ret = 32'd0;  exp_red = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fetch_with(BEQW); retire(1'b0, 2'b00, 1'b0, 32'h0);
    end
    fetch_with(BEQW); retire(1'b0, 2'b10, 1'b0, 32'h1);
    fetch_with(BEQW); retire(1'b0, 2'b10, 1'b1, 32'h1);
    fetch_with(BEQW); retire(1'b0, 2'b11, 1'b0, 32'h2);
    fetch_with(BEQW); retire(1'b0, 2'b10, 1'b1, 32'h1);
    fetch_with(J10);  retire(1'b1, 2'b00, 1'b0, 32'h0);
    chk_addr("cnt_final_pc", 32'h40);
    checks++;
    if (retired_cnt !== exp_ret) begin
      errors++; $display("FAIL retired_cnt: got %0d required %0d", retired_cnt, exp_ret);
    end
    checks++;
    if (redirect_cnt !== exp_red) begin
      errors++; $display("FAIL redirect_cnt: got %0d required %0d", redirect_cnt, exp_red);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_bne();
    test_jump();
    test_hold_stall();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
